// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Brief    : Shared FSM encoding and default sizes for the trace sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DISPLAY = 2'd3
    } trace_state_e;

    localparam int DEFAULT_DATA_WIDTH = 20;
    localparam int DEFAULT_DEPTH      = 1280;
    localparam int DEFAULT_ADDR_WIDTH = 11;
    localparam int DEFAULT_DIV_WIDTH  = 8;
    localparam int X_WIDTH            = 11;

endpackage
`default_nettype wire

// File: rtl/trace_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trace_sequencer_if
//  Brief    : Probe, control, replay and status bundle of the trace sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface trace_sequencer_if
    import trace_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int div_width  = DEFAULT_DIV_WIDTH
);
    logic [data_width-1:0] probe;
    logic                  arm;
    logic                  abort;
    logic [data_width-1:0] trig_mask;
    logic [data_width-1:0] trig_value;
    logic [div_width-1:0]  divider;
    logic [X_WIDTH-1:0]    x;
    logic [data_width-1:0] state;
    logic [data_width-1:0] buf_data;
    logic                  armed;
    logic                  busy;
    logic                  done;
    logic                  irq;

    modport master (
        output probe, arm, abort, trig_mask, trig_value, divider, x,
        input  state, buf_data, armed, busy, done, irq
    );

    modport slave (
        input  probe, arm, abort, trig_mask, trig_value, divider, x,
        output state, buf_data, armed, busy, done, irq
    );

endinterface
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module   : trace_ram
//  Brief    : Sample store, one write port and two registered read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_ram
    import trace_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int depth      = DEFAULT_DEPTH,
    parameter int addr_width = DEFAULT_ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  we_i,
    input  wire logic [addr_width-1:0] waddr_i,
    input  wire logic [data_width-1:0] wdata_i,
    input  wire logic [addr_width-1:0] raddr_a_i,
    input  wire logic [addr_width-1:0] raddr_b_i,
    output logic      [data_width-1:0] rdata_a_o,
    output logic      [data_width-1:0] rdata_b_o
);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rdata_a_q;
    logic [data_width-1:0] rdata_b_q;

    // No reset on the array or read registers so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_a_q <= mem_q[raddr_a_i];
        rdata_b_q <= mem_q[raddr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule
`default_nettype wire

// File: rtl/trace_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : trace_sequencer
//  Brief    : Arms on command, captures a triggered trace, replays it per column.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_sequencer
    import trace_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int depth      = DEFAULT_DEPTH,
    parameter int addr_width = DEFAULT_ADDR_WIDTH,
    parameter int div_width  = DEFAULT_DIV_WIDTH
) (
    input wire logic    clk,
    input wire logic    rst,
    trace_sequencer_if.slave bus
);

    localparam int                    c_x_ext_w   = X_WIDTH + 1;
    localparam logic [addr_width-1:0] c_last_addr = addr_width'(depth - 1);
    localparam logic [c_x_ext_w-1:0]  c_depth_x   = c_x_ext_w'(depth);

    trace_state_e          fsm_q;
    logic                  armed_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  irq_q;
    logic [div_width-1:0]  div_q;
    logic [div_width-1:0]  cnt_q;
    logic [data_width-1:0] mask_q;
    logic [data_width-1:0] value_q;
    logic [addr_width-1:0] waddr_q;
    logic                  valid_q;

    logic                  w_trig;
    logic                  w_tick;
    logic                  w_we;
    logic [addr_width-1:0] w_waddr;
    logic                  w_rd_en;
    logic [X_WIDTH-1:0]    w_x_prev;
    logic [addr_width-1:0] w_raddr_a;
    logic [addr_width-1:0] w_raddr_b;
    logic [data_width-1:0] w_ram_a;
    logic [data_width-1:0] w_ram_b;

    assign w_trig  = ((bus.probe & mask_q) == (value_q & mask_q));
    assign w_tick  = (cnt_q == div_q);

    // The trigger cycle itself stores sample 0, so ARMED writes straight to address 0.
    assign w_we    = !bus.abort &&
                     (((fsm_q == ST_ARMED) && w_trig) ||
                      ((fsm_q == ST_CAPTURE) && w_tick));
    assign w_waddr = (fsm_q == ST_ARMED) ? '0 : waddr_q;

    assign w_rd_en   = (fsm_q == ST_DISPLAY) && ({1'b0, bus.x} < c_depth_x);
    assign w_x_prev  = (bus.x == '0) ? '0 : (bus.x - X_WIDTH'(1));
    assign w_raddr_a = w_rd_en ? addr_width'(bus.x)    : '0;
    assign w_raddr_b = w_rd_en ? addr_width'(w_x_prev) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            value_q <= '0;
            waddr_q <= '0;
        end else begin
            irq_q <= 1'b0;
            if (bus.abort) begin
                fsm_q   <= ST_IDLE;
                armed_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (fsm_q)
                    ST_IDLE, ST_DISPLAY: begin
                        if (bus.arm) begin
                            div_q   <= bus.divider;
                            mask_q  <= bus.trig_mask;
                            value_q <= bus.trig_value;
                            fsm_q   <= ST_ARMED;
                            armed_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (w_trig) begin
                            cnt_q   <= '0;
                            waddr_q <= addr_width'(1);
                            fsm_q   <= ST_CAPTURE;
                            armed_q <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (w_tick) begin
                            cnt_q   <= '0;
                            waddr_q <= waddr_q + addr_width'(1);
                            if (waddr_q == c_last_addr) begin
                                fsm_q  <= ST_DISPLAY;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                irq_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + div_width'(1);
                        end
                    end
                    default: begin
                        fsm_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Tracks whether the RAM word arriving next cycle is a real replay value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= w_rd_en;
        end
    end

    trace_ram #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_ram (
        .clk       (clk),
        .we_i      (w_we),
        .waddr_i   (w_waddr),
        .wdata_i   (bus.probe),
        .raddr_a_i (w_raddr_a),
        .raddr_b_i (w_raddr_b),
        .rdata_a_o (w_ram_a),
        .rdata_b_o (w_ram_b)
    );

    assign bus.state    = valid_q ? w_ram_a : '0;
    assign bus.buf_data = valid_q ? w_ram_b : '0;
    assign bus.armed    = armed_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_sequencer
//  Brief    : Scoreboard bench for capture timing, trigger and replay of trace_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trace_sequencer;

    localparam int c_depth = 1280;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_sequencer_if bus ();

    trace_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          total    = 0;
    int          bad      = 0;
    logic        cnt_en   = 1'b0;
    logic        disp_exp = 1'b0;
    logic [19:0] m [c_depth];
    logic [19:0] q_s [$];
    logic [19:0] q_b [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (cnt_en) bus.probe = bus.probe + 20'd1;
    endtask

    task automatic do_arm(input logic [19:0] mask, input logic [19:0] value, input logic [7:0] div);
        bus.trig_mask  = mask;
        bus.trig_value = value;
        bus.divider    = div;
        bus.arm        = 1'b1;
        step();
        bus.arm        = 1'b0;
    endtask

    task automatic fill_model(input logic [19:0] start, input int stride);
        for (int k = 0; k < c_depth; k++) m[k] = start + 20'(k * stride);
    endtask

    task automatic check_flags(input string tag, input logic a, input logic b, input logic d);
        check_val({tag, " armed"}, 32'(bus.armed), 32'(a));
        check_val({tag, " busy"},  32'(bus.busy),  32'(b));
        check_val({tag, " done"},  32'(bus.done),  32'(d));
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int   n    = 0;
        int   irqs = 0;
        logic irq_at_done;
        while (!bus.done && n < exp_cycles + 64) begin
            step();
            n++;
            if (bus.irq) irqs++;
        end
        irq_at_done = bus.irq;
        check_val({tag, " cycles"}, 32'(n), 32'(exp_cycles));
        check_val({tag, " irq at entry"}, 32'(irq_at_done), 32'd1);
        repeat (3) begin
            step();
            if (bus.irq) irqs++;
        end
        check_val({tag, " irq count"}, 32'(irqs), 32'd1);
        disp_exp = 1'b1;
    endtask

    task automatic replay(input logic [10:0] xv);
        logic [19:0] es;
        logic [19:0] eb;
        bus.x = xv;
        if (!disp_exp || xv >= 11'd1280) begin
            es = '0;
            eb = '0;
        end else if (xv == 11'd0) begin
            es = m[0];
            eb = m[0];
        end else begin
            es = m[xv];
            eb = m[xv - 11'd1];
        end
        q_s.push_back(es);
        q_b.push_back(eb);
        step();
        check_val($sformatf("state x=%0d", xv),    32'(bus.state),    32'(q_s.pop_front()));
        check_val($sformatf("buf_data x=%0d", xv), 32'(bus.buf_data), 32'(q_b.pop_front()));
    endtask

    initial begin
        bus.probe      = '0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.trig_mask  = '0;
        bus.trig_value = '0;
        bus.divider    = '0;
        bus.x          = '0;

        repeat (3) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_val("reset irq",      32'(bus.irq),      32'd0);
        check_val("reset state",    32'(bus.state),    32'd0);
        check_val("reset buf_data", 32'(bus.buf_data), 32'd0);
        rst = 1'b0;
        step();
        replay(11'd5);

        // Reset while capturing
        cnt_en = 1'b1;
        do_arm(20'h0, 20'h0, 8'd0);
        repeat (100) step();
        check_val("midcap busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_flags("midcap reset", 1'b0, 1'b0, 1'b0);
        check_val("midcap reset irq", 32'(bus.irq), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_flags("after reset", 1'b0, 1'b0, 1'b0);

        // Immediate trigger, divider 0, counting probe from 100
        bus.probe = 20'd99;
        do_arm(20'h0, 20'h0, 8'd0);
        check_flags("armed div0", 1'b1, 1'b1, 1'b0);
        fill_model(20'd100, 1);
        wait_done("cap div0", 1280);
        check_flags("display div0", 1'b0, 1'b0, 1'b1);
        replay(11'd5);
        replay(11'd0);
        replay(11'd1279);
        replay(11'd1280);
        replay(11'd2047);
        replay(11'd3);

        // Arm and abort together in DISPLAY
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        disp_exp  = 1'b0;
        check_flags("arm+abort", 1'b0, 1'b0, 1'b0);
        replay(11'd5);
        replay(11'd0);

        // Masked trigger on the low nibble
        bus.probe = 20'd0;
        do_arm(20'h0000F, 20'h00003, 8'd0);
        fill_model(20'd3, 1);
        wait_done("cap mask", 1282);
        replay(11'd0);
        replay(11'd1);
        replay(11'd1279);

        // Divider 3, re-armed from DISPLAY
        bus.probe = 20'd999;
        do_arm(20'h0, 20'h0, 8'd3);
        disp_exp = 1'b0;
        fill_model(20'd1000, 4);
        wait_done("cap div3", 5117);
        replay(11'd0);
        replay(11'd1);
        replay(11'd640);
        replay(11'd2);
        replay(11'd1279);

        // Arm while ARMED must not restart or change config
        cnt_en    = 1'b0;
        bus.probe = 20'd0;
        do_arm(20'hFFFFF, 20'hABCDE, 8'd1);
        disp_exp = 1'b0;
        check_flags("armed strict", 1'b1, 1'b1, 1'b0);
        do_arm(20'h0, 20'h0, 8'd5);
        repeat (3) step();
        check_flags("rearm ignored", 1'b1, 1'b1, 1'b0);
        bus.probe = 20'hABCDE;
        cnt_en    = 1'b1;
        fill_model(20'hABCDE, 2);
        wait_done("cap div1", 2559);
        replay(11'd700);
        replay(11'd0);
        replay(11'd1279);
        replay(11'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
